// File: rtl/par2ser_old2new_unify_pkg.sv
// Shared definitions for the delay-line unpack blocks: FSM state type and a
// constant clog2 used to size beat counters.
package par2ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/par2ser_old2new_unify_if.sv
// Snapshot-in / element-out handshake bundle for the parallel-to-serial unloader.
interface par2ser_old2new_unify_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned LEN   = 2
);
    logic [WIDTH*LEN-1:0] IN_NEW2OLD_I;
    logic                 IN_VALID_I;
    logic                 IN_READY_O;
    logic [WIDTH-1:0]     OUT_O;
    logic                 OUT_VALID_O;
    logic                 OUT_READY_I;
    logic                 OUT_LAST_O;
    logic                 BUSY_O;

    modport slave (
        input  IN_NEW2OLD_I,
        input  IN_VALID_I,
        output IN_READY_O,
        output OUT_O,
        output OUT_VALID_O,
        input  OUT_READY_I,
        output OUT_LAST_O,
        output BUSY_O
    );

    modport master (
        output IN_NEW2OLD_I,
        output IN_VALID_I,
        input  IN_READY_O,
        input  OUT_O,
        input  OUT_VALID_O,
        output OUT_READY_I,
        input  OUT_LAST_O,
        input  BUSY_O
    );
endinterface

// File: rtl/par2ser_old2new_unify.sv
// Unloads a newest..oldest snapshot one element per beat, oldest first, with
// gapless reload on the last beat.
module par2ser_old2new_unify
    import par2ser_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned LEN   = 2
) (
    input  logic CLK_I,
    input  logic RSTN_I,
    par2ser_old2new_unify_if.slave bus
);

    localparam int unsigned CNT_W = (clog2(LEN) > 1) ? clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_e               state_q, state_d;
    logic [WIDTH*LEN-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 in_ready;
    logic                 out_valid;
    logic                 out_last;
    logic                 busy;
    logic [WIDTH-1:0]     out_data;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.IN_VALID_I) begin
                    buf_d   = bus.IN_NEW2OLD_I;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (cnt_q == CNT_LAST);
                // Beat cnt reads slice LEN-1-cnt, so the oldest element leaves first.
                for (int unsigned i = 0; i < LEN; i++) begin
                    if (cnt_q == CNT_W'(LEN - 1 - i)) begin
                        out_data = buf_q[WIDTH*i +: WIDTH];
                    end
                end
                in_ready = out_last && bus.OUT_READY_I;
                if (bus.OUT_READY_I) begin
                    if (!out_last) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (bus.IN_VALID_I) begin
                        buf_d = bus.IN_NEW2OLD_I;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.IN_READY_O  = in_ready;
    assign bus.OUT_VALID_O = out_valid;
    assign bus.OUT_LAST_O  = out_last;
    assign bus.BUSY_O      = busy;
    assign bus.OUT_O       = out_data;

endmodule

// File: tb/tb_par2ser_old2new_unify.sv
// Bench for par2ser_old2new_unify: directed vector table (WIDTH=8, LEN=4),
// hand-written LEN=1 sequence, then random traffic against a queue model.
module tb_par2ser_old2new_unify;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    par2ser_old2new_unify_if #(.WIDTH(8), .LEN(4)) bus0 ();
    par2ser_old2new_unify_if #(.WIDTH(4), .LEN(1)) bus1 ();

    par2ser_old2new_unify #(.WIDTH(8), .LEN(4)) dut0 (
        .CLK_I  (clk),
        .RSTN_I (rstn),
        .bus    (bus0)
    );

    par2ser_old2new_unify #(.WIDTH(4), .LEN(1)) dut1 (
        .CLK_I  (clk),
        .RSTN_I (rstn),
        .bus    (bus1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rstn;
        logic        iv;
        logic [31:0] data;
        logic        ordy;
        logic        chk;
        logic        rdy;
        logic        val;
        logic        last;
        logic [7:0]  out;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic iv, logic [31:0] d, logic ordy,
                                logic chk, logic rdy, logic val, logic last,
                                logic [7:0] out);
        vec_t v;
        v.rstn = r; v.iv = iv; v.data = d; v.ordy = ordy; v.chk = chk;
        v.rdy = rdy; v.val = val; v.last = last; v.out = out;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack0();
        return {52'd0, bus0.IN_READY_O, bus0.OUT_VALID_O, bus0.OUT_LAST_O,
                bus0.BUSY_O, bus0.OUT_O};
    endfunction

    function automatic logic [63:0] pack1();
        return {56'd0, bus1.IN_READY_O, bus1.OUT_VALID_O, bus1.OUT_LAST_O,
                bus1.BUSY_O, bus1.OUT_O};
    endfunction

    // Expected tuple {in_ready, valid, last, busy, data}; busy tracks valid.
    function automatic logic [63:0] exp8(logic rdy, logic val, logic last, logic [7:0] d);
        return {52'd0, rdy, val, last, val, d};
    endfunction

    function automatic logic [63:0] exp4(logic rdy, logic val, logic last, logic [3:0] d);
        return {56'd0, rdy, val, last, val, d};
    endfunction

    task automatic step1(logic iv, logic [3:0] d, logic ordy, string name,
                         logic rdy, logic val, logic last, logic [3:0] out);
        @(negedge clk);
        bus1.IN_VALID_I   = iv;
        bus1.IN_NEW2OLD_I = d;
        bus1.OUT_READY_I  = ordy;
        #1;
        check(name, pack1(), exp4(rdy, val, last, out));
    endtask

    logic [7:0] q0[$];
    logic [3:0] q1[$];

    initial begin
        bus0.IN_VALID_I = 1'b0; bus0.IN_NEW2OLD_I = '0; bus0.OUT_READY_I = 1'b0;
        bus1.IN_VALID_I = 1'b0; bus1.IN_NEW2OLD_I = '0; bus1.OUT_READY_I = 1'b0;

        // reset and idle
        add(0, 0, 32'h0,        0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 32'h0,        0, 1, 1, 0, 0, 8'h00);
        add(1, 0, 32'h0,        0, 1, 1, 0, 0, 8'h00);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);
        // single snapshot
        add(1, 1, 32'h44332211, 1, 1, 1, 0, 0, 8'h00);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h33);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h22);
        add(1, 0, 32'h0,        1, 1, 1, 1, 1, 8'h11);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);
        // stall on the first beat; upstream activity ignored meanwhile
        add(1, 1, 32'h44332211, 0, 1, 1, 0, 0, 8'h00);
        add(1, 1, 32'hFFFFFFFF, 0, 1, 0, 1, 0, 8'h44);
        add(1, 1, 32'h99887766, 0, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        0, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h33);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h22);
        add(1, 0, 32'h0,        1, 1, 1, 1, 1, 8'h11);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);
        // back-to-back snapshots, IN_VALID_I held
        add(1, 1, 32'h44332211, 1, 1, 1, 0, 0, 8'h00);
        add(1, 1, 32'hDDCCBBAA, 1, 1, 0, 1, 0, 8'h44);
        add(1, 1, 32'hDDCCBBAA, 1, 1, 0, 1, 0, 8'h33);
        add(1, 1, 32'hDDCCBBAA, 1, 1, 0, 1, 0, 8'h22);
        add(1, 1, 32'hDDCCBBAA, 1, 1, 1, 1, 1, 8'h11);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'hDD);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'hCC);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'hBB);
        add(1, 0, 32'h0,        1, 1, 1, 1, 1, 8'hAA);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);
        // reset mid-unload, then restart
        add(1, 1, 32'h44332211, 1, 1, 1, 0, 0, 8'h00);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h33);
        add(0, 0, 32'h0,        1, 1, 0, 1, 0, 8'h22);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);
        add(1, 1, 32'h44332211, 1, 1, 1, 0, 0, 8'h00);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h44);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h33);
        add(1, 0, 32'h0,        1, 1, 0, 1, 0, 8'h22);
        add(1, 0, 32'h0,        1, 1, 1, 1, 1, 8'h11);
        add(1, 0, 32'h0,        1, 1, 1, 0, 0, 8'h00);

        foreach (tbl[i]) begin
            @(negedge clk);
            rstn              = tbl[i].rstn;
            bus0.IN_VALID_I   = tbl[i].iv;
            bus0.IN_NEW2OLD_I = tbl[i].data;
            bus0.OUT_READY_I  = tbl[i].ordy;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d", i), pack0(),
                      exp8(tbl[i].rdy, tbl[i].val, tbl[i].last, tbl[i].out));
                if (tbl[i].rstn) begin
                    // LEN=1 unit is held idle here and must look idle too
                    check($sformatf("len1_idle%0d", i), pack1(), exp4(1, 0, 0, 4'h0));
                end
            end
        end
        bus0.IN_VALID_I  = 1'b0;
        bus0.OUT_READY_I = 1'b0;

        // LEN=1: every beat is last; immediate reload without a gap
        step1(1, 4'hA, 1, "len1_load",   1, 0, 0, 4'h0);
        step1(1, 4'h5, 1, "len1_beatA",  1, 1, 1, 4'hA);
        step1(0, 4'h3, 0, "len1_stall5", 0, 1, 1, 4'h5);
        step1(0, 4'h3, 1, "len1_beat5",  1, 1, 1, 4'h5);
        step1(0, 4'h0, 1, "len1_idle",   1, 0, 0, 4'h0);

        // random traffic vs. a queue of elements still owed downstream
        for (int n = 0; n < 600; n++) begin
            logic [31:0] d0;
            logic [3:0]  d1;
            logic        iv0, iv1, or0, or1, er0, er1;
            d0  = $urandom;
            d1  = 4'($urandom);
            iv0 = ($urandom_range(0, 2) != 0);
            iv1 = ($urandom_range(0, 2) != 0);
            or0 = ($urandom_range(0, 3) != 0);
            or1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            bus0.IN_VALID_I = iv0; bus0.IN_NEW2OLD_I = d0; bus0.OUT_READY_I = or0;
            bus1.IN_VALID_I = iv1; bus1.IN_NEW2OLD_I = d1; bus1.OUT_READY_I = or1;
            #1;
            er0 = (q0.size() == 0) || (q0.size() == 1 && or0);
            er1 = (q1.size() == 0) || (q1.size() == 1 && or1);
            check("rand_len4", pack0(),
                  exp8(er0, q0.size() != 0, q0.size() == 1,
                       (q0.size() != 0) ? q0[0] : 8'h00));
            check("rand_len1", pack1(),
                  exp4(er1, q1.size() != 0, q1.size() == 1,
                       (q1.size() != 0) ? q1[0] : 4'h0));
            if (q0.size() != 0 && or0) void'(q0.pop_front());
            if (iv0 && er0) begin
                for (int k = 3; k >= 0; k--) q0.push_back(d0[8*k +: 8]);
            end
            if (q1.size() != 0 && or1) void'(q1.pop_front());
            if (iv1 && er1) q1.push_back(d1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
